oh_gpio_ctrl: RTL

Core-side controller for the GPIO pad ring. It drives the ring's per-pin `dout`, `oen`, `ie` and 8-bit `cfg` inputs from a memory-mapped register file. It samples the ring's `din` outputs through a synchronizer and raises a maskable edge/level interrupt. It sits between the SoC register bus and the GPIO pad ring instance, one controller per ring.

---
 rtl/oh_gpio_ctrl_if.sv | 21 ++
 rtl/oh_gpio_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/oh_gpio_ctrl_if.sv
// Register bus between the SoC fabric and one GPIO ring controller.
// Single-cycle strobe, read data returned one cycle later; no stall signal.
interface oh_gpio_ctrl_if #(
    parameter int AW = 5
);
    logic          reg_access;
    logic          reg_write;
    logic [AW-1:0] reg_addr;
    logic [31:0]   reg_wdata;
    logic [31:0]   reg_rdata;

    modport master (
        output reg_access, reg_write, reg_addr, reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_access, reg_write, reg_addr, reg_wdata,
        output reg_rdata
    );
endinterface

// File: rtl/oh_gpio_ctrl.sv
// GPIO pad-ring controller: pad drive/config registers, 2-flop input sync, maskable edge/level IRQ.
// Writes land at the sampling edge, read data one cycle after the strobe; accepts a transaction every cycle.
module oh_gpio_ctrl #(
    parameter int NGPIO = 8,
    parameter int AW    = 5
) (
    input  logic               clk,
    input  logic               reset,
    oh_gpio_ctrl_if.slave      bus,
    output logic [NGPIO-1:0]   gpio_dout,
    output logic [NGPIO-1:0]   gpio_oen,
    output logic [NGPIO-1:0]   gpio_ie,
    output logic [NGPIO*8-1:0] gpio_cfg,
    input  logic [NGPIO-1:0]   gpio_din,
    output logic               irq
);
    localparam int NCFGW = (NGPIO + 3) / 4;
    localparam int CFGPW = NCFGW * 32;

    localparam logic [31:0] A_OUT    = 32'd0;
    localparam logic [31:0] A_OEN    = 32'd1;
    localparam logic [31:0] A_IE     = 32'd2;
    localparam logic [31:0] A_IN     = 32'd3;
    localparam logic [31:0] A_IMASK  = 32'd4;
    localparam logic [31:0] A_ITYPE  = 32'd5;
    localparam logic [31:0] A_IPOL   = 32'd6;
    localparam logic [31:0] A_ISTAT  = 32'd7;
    localparam logic [31:0] A_OUTSET = 32'd8;
    localparam logic [31:0] A_OUTCLR = 32'd9;
    localparam logic [31:0] A_OUTTGL = 32'd10;
    localparam logic [31:0] A_CFG    = 32'd16;

    logic [NGPIO-1:0]   out_q, out_d;
    logic [NGPIO-1:0]   oen_q, oen_d;
    logic [NGPIO-1:0]   ie_q, ie_d;
    logic [NGPIO-1:0]   imask_q, imask_d;
    logic [NGPIO-1:0]   itype_q, itype_d;
    logic [NGPIO-1:0]   ipol_q, ipol_d;
    logic [NGPIO-1:0]   istat_q, istat_d;
    logic [NGPIO*8-1:0] cfg_q, cfg_d;
    logic [NGPIO-1:0]   s1_q, s2_q, s3_q;
    logic [31:0]        rdata_q, rdata_d;

    logic [AW-1:0]      addr_w;
    logic [31:0]        addr;
    logic               wr_en;
    logic               rd_en;
    logic [NGPIO-1:0]   wv;
    logic [NGPIO-1:0]   istat_clr;
    logic [NGPIO-1:0]   irq_cond;
    logic [CFGPW-1:0]   cfg_pad;

    function automatic logic [31:0] ext(input logic [NGPIO-1:0] v);
        return 32'(v);
    endfunction

    assign addr_w = bus.reg_addr;
    assign addr   = 32'(addr_w);
    assign wr_en  = bus.reg_access & bus.reg_write;
    assign rd_en  = bus.reg_access & ~bus.reg_write;
    assign wv     = bus.reg_wdata[NGPIO-1:0];

    // Edge terms compare synchronized s2 against its one-cycle-old copy s3.
    assign irq_cond = ( itype_q & ((ipol_q & s2_q & ~s3_q) | (~ipol_q & ~s2_q & s3_q)))
                    | (~itype_q & ((ipol_q & s2_q) | (~ipol_q & ~s2_q)));

    always_comb begin
        cfg_pad                = '0;
        cfg_pad[NGPIO*8-1:0]   = cfg_q;
    end

    always_comb begin
        out_d     = out_q;
        oen_d     = oen_q;
        ie_d      = ie_q;
        imask_d   = imask_q;
        itype_d   = itype_q;
        ipol_d    = ipol_q;
        cfg_d     = cfg_q;
        istat_clr = '0;
        if (wr_en) begin
            case (addr)
                A_OUT:    out_d     = wv;
                A_OEN:    oen_d     = wv;
                A_IE:     ie_d      = wv;
                A_IMASK:  imask_d   = wv;
                A_ITYPE:  itype_d   = wv;
                A_IPOL:   ipol_d    = wv;
                A_ISTAT:  istat_clr = wv;
                A_OUTSET: out_d     = out_q | wv;
                A_OUTCLR: out_d     = out_q & ~wv;
                A_OUTTGL: out_d     = out_q ^ wv;
                default: ;
            endcase
            for (int p = 0; p < NGPIO; p++) begin
                if (addr == A_CFG + 32'(p / 4))
                    cfg_d[p*8 +: 8] = bus.reg_wdata[(p % 4)*8 +: 8];
            end
        end
        // A new condition outranks a same-cycle write-1-to-clear.
        istat_d = (istat_q & ~istat_clr) | irq_cond;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (addr)
                A_OUT:   rdata_d = ext(out_q);
                A_OEN:   rdata_d = ext(oen_q);
                A_IE:    rdata_d = ext(ie_q);
                A_IN:    rdata_d = ext(s2_q);
                A_IMASK: rdata_d = ext(imask_q);
                A_ITYPE: rdata_d = ext(itype_q);
                A_IPOL:  rdata_d = ext(ipol_q);
                A_ISTAT: rdata_d = ext(istat_q);
                default: rdata_d = '0;
            endcase
            for (int k = 0; k < NCFGW; k++) begin
                if (addr == A_CFG + 32'(k))
                    rdata_d = cfg_pad[k*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            oen_q   <= '1;
            ie_q    <= '0;
            imask_q <= '0;
            itype_q <= '0;
            ipol_q  <= '0;
            istat_q <= '0;
            cfg_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            rdata_q <= '0;
        end else begin
            out_q   <= out_d;
            oen_q   <= oen_d;
            ie_q    <= ie_d;
            imask_q <= imask_d;
            itype_q <= itype_d;
            ipol_q  <= ipol_d;
            istat_q <= istat_d;
            cfg_q   <= cfg_d;
            s1_q    <= gpio_din;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            rdata_q <= rdata_d;
        end
    end

    assign gpio_dout     = out_q;
    assign gpio_oen      = oen_q;
    assign gpio_ie       = ie_q;
    assign gpio_cfg      = cfg_q;
    assign bus.reg_rdata = rdata_q;
    assign irq           = |(istat_q & imask_q);
endmodule
